// File: rtl/adder_arb_ctrl_pkg.sv
// Shared constants and types for the adder arbitration front-end:
// FSM state encodings, adder width and the in-flight tag layout.
package adder_arb_ctrl_pkg;

  localparam int ADD_W     = 32;
  localparam int TAG_IDX_W = 3;  // wide enough for up to 8 requesters

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOCK = 2'd2
  } st_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic                 chain;
  } tag_t;

endpackage

// File: rtl/adder_arb_ctrl_if.sv
// Requester and adder-side bus of adder_arb_ctrl. The slave modport is the
// controller; the master modport is the requester/adder environment.
interface adder_arb_ctrl_if #(
  parameter int N = 4,
  parameter int W = 32
);
  // A request transfers in any cycle where req_valid[i] & req_ready[i]; the
  // requester holds its fields stable while valid is high and not yet ready.
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_chain;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_s;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, add_s, add_cout,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, add_s, add_cout,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_arb_ctrl_rr_arbiter.sv
// Grant logic for adder_arb_ctrl. RR_ARB_EN selects round-robin from an
// internal pointer; otherwise fixed priority, lowest index first.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

`ifdef RR_ARB_EN
  logic [IW-1:0] ptr_q;
  logic          found;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, en};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/adder_arb_ctrl.sv
// Arbitration/sequencing front-end for a shared registered adder, with
// locked multi-word carry chains. Grant policy set by RR_ARB_EN (rr_arbiter).
module adder_arb_ctrl
  import adder_arb_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = ADD_W,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_arb_ctrl_if.slave  bus,
  output logic             busy,
  output st_t              state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  st_t           state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          carry_q;
  logic [N-1:0]  grant, ready;
  logic [IW-1:0] grant_idx, acc_idx;
  logic          accept, acc_chain, sel_cin, arb_en, owner_ret;
  logic [W-1:0]  sel_a, sel_b;
  tag_t          tag_in, tag_ret;
  tag_t          tag_q [ADD_LAT+1];

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready is forced low while reset is held so no transfer can be seen.
  always_comb begin
    ready = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: ready = grant;
        ST_LOCK: begin
          for (int i = 0; i < N; i++) begin
            if (IW'(i) == owner_q) ready[i] = bus.req_valid[i];
          end
        end
        default: ready = '0;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);
  assign arb_en        = accept && (state_q == ST_IDLE);

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_cin   = 1'b0;
    acc_chain = 1'b0;
    acc_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && ready[i]) begin
        sel_a     = bus.req_a[i*W +: W];
        sel_b     = bus.req_b[i*W +: W];
        sel_cin   = bus.req_cin[i];
        acc_chain = bus.req_chain[i];
        acc_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.idx   = TAG_IDX_W'(acc_idx);
    tag_in.chain = acc_chain;
  end

  assign tag_ret   = tag_q[ADD_LAT];
  assign owner_ret = tag_ret.valid && tag_ret.chain &&
                     (tag_ret.idx == TAG_IDX_W'(owner_q));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && acc_chain) begin
          state_d = ST_WAIT;
          owner_d = grant_idx;
        end
      end
      ST_WAIT: if (owner_ret) state_d = ST_LOCK;
      ST_LOCK: if (accept) state_d = acc_chain ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      bus.add_a   <= '0;
      bus.add_b   <= '0;
      bus.add_cin <= 1'b0;
      for (int k = 0; k <= ADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if ((state_q == ST_WAIT) && owner_ret) carry_q <= bus.add_cout;
      if (accept) begin
        bus.add_a   <= sel_a;
        bus.add_b   <= sel_b;
        bus.add_cin <= (state_q == ST_LOCK) ? carry_q : sel_cin;
      end
      tag_q[0] <= tag_in;
      for (int k = 1; k <= ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // The sum and carry pass straight through; only the tag decides the owner.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (tag_ret.valid && (tag_ret.idx == TAG_IDX_W'(i))) bus.rsp_valid[i] = 1'b1;
    end
  end

  assign bus.rsp_sum  = bus.add_s;
  assign bus.rsp_cout = bus.add_cout;

  always_comb begin
    busy = (state_q != ST_IDLE);
    for (int k = 0; k <= ADD_LAT; k++) busy = busy | tag_q[k].valid;
  end

  assign state = state_q;

endmodule
